// File: rtl/nios_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nios_timer_pkg
// Description : Shared constants for the multi-channel NIOS interval timer:
//               per-channel register offsets and bit positions inside the
//               STATUS and CONTROL words.
// Revision    : 1.0  initial release
// ============================================================================
package nios_timer_pkg;

    // Register offsets inside one channel's four-word window
    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_SNAP    = 2'd3;

    // STATUS bits
    localparam int TO_BIT    = 0;
    localparam int RUN_BIT   = 1;

    // CONTROL bits
    localparam int ITO_BIT   = 0;
    localparam int CONT_BIT  = 1;
    localparam int START_BIT = 2;
    localparam int STOP_BIT  = 3;
    localparam int PRESC_LSB = 8;
    localparam int PRESC_MSB = 15;

endpackage
`default_nettype wire

// File: rtl/nios_multi_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : nios_multi_timer_if
// Description : Avalon-MM slave bus plus interrupt outputs of the
//               multi-channel timer.
//   address    {channel, reg[1:0]}
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   registered read data
//   irq        OR of irq_vec
//   irq_vec    per-channel interrupt
// Revision    : 1.0  initial release
// ============================================================================
interface nios_multi_timer_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
);
    localparam int ADDR_W = $clog2(NUM_CH) + 2;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq, irq_vec
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq, irq_vec
    );
endinterface
`default_nettype wire

// File: rtl/nios_timer_channel.sv
`default_nettype none
// ============================================================================
// Module      : nios_timer_channel
// Description : One timer channel: down-counter, period, snapshot, control,
//               status and (optionally) an 8-bit prescaler.
//   clk, reset_n        clock and synchronous active-low reset
//   wr_status/control/
//   wr_period/wr_snap   single-cycle write strobes, already decoded
//   wdata               write data
//   reg_sel             register selected for the read word
//   rd_word             read word of the selected register
//   irq                 TO & ITO
// Optional feature macro: NIOS_TIMER_PRESCALE_EN (CONTROL[15:8] prescaler)
// Revision    : 1.0  initial release
// ============================================================================
module nios_timer_channel
    import nios_timer_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DATA_W       = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              wr_status,
    input  wire logic              wr_control,
    input  wire logic              wr_period,
    input  wire logic              wr_snap,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [1:0]        reg_sel,
    output logic      [DATA_W-1:0] rd_word,
    output logic                   irq
);
    localparam logic [CNT_W-1:0] c_reset_period = CNT_W'(RESET_PERIOD);
    localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);

    logic [CNT_W-1:0] r_counter;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_snap;
    logic             r_ito;
    logic             r_cont;
    logic             r_run;
    logic             r_to;
    logic             r_reload_pend;  // PERIOD was written last cycle
    logic             r_cnt_nz_d;     // counter was non-zero last cycle

    logic w_start;
    logic w_stop;
    logic w_zero;
    logic w_event;
    logic w_tick;
    logic w_unused_wdata;

    assign w_start        = wr_control & wdata[START_BIT];
    assign w_stop         = wr_control & wdata[STOP_BIT];
    assign w_zero         = (r_counter == '0);
    assign w_event        = w_zero & r_cnt_nz_d;
    assign w_unused_wdata = ^wdata;

`ifdef NIOS_TIMER_PRESCALE_EN
    logic [7:0] r_presc;
    logic [7:0] r_presc_cnt;
    logic [7:0] w_presc_next;

    // A START written together with a new PRESC must reload the new value.
    assign w_presc_next = wr_control ? wdata[PRESC_MSB:PRESC_LSB] : r_presc;
    assign w_tick       = r_run & (r_presc_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc     <= 8'd0;
            r_presc_cnt <= 8'd0;
        end else begin
            if (wr_control) begin
                r_presc <= wdata[PRESC_MSB:PRESC_LSB];
            end
            if (w_start | r_reload_pend) begin
                r_presc_cnt <= w_presc_next;
            end else if (r_run) begin
                r_presc_cnt <= (r_presc_cnt == 8'd0) ? r_presc : r_presc_cnt - 8'd1;
            end
        end
    end
`else
    assign w_tick = r_run;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_counter     <= c_reset_period;
            r_period      <= c_reset_period;
            r_snap        <= '0;
            r_ito         <= 1'b0;
            r_cont        <= 1'b0;
            r_run         <= 1'b0;
            r_to          <= 1'b0;
            r_reload_pend <= 1'b0;
            r_cnt_nz_d    <= (RESET_PERIOD != 0);
        end else begin
            r_reload_pend <= wr_period;
            r_cnt_nz_d    <= ~w_zero;

            if (wr_period) begin
                r_period <= wdata[CNT_W-1:0];
            end
            if (wr_snap) begin
                r_snap <= r_counter;
            end
            if (wr_control) begin
                r_ito  <= wdata[ITO_BIT];
                r_cont <= wdata[CONT_BIT];
            end

            // Forced reload beats normal counting; it uses the new period.
            if (r_reload_pend) begin
                r_counter <= r_period;
            end else if (w_tick) begin
                r_counter <= w_zero ? r_period : r_counter - c_one;
            end

            // START dominates every reason to stop.
            if (w_start) begin
                r_run <= 1'b1;
            end else if (w_stop | r_reload_pend) begin
                r_run <= 1'b0;
            end else if (r_run & w_zero & ~r_cont) begin
                r_run <= 1'b0;
            end

            // A STATUS write clears TO even against a same-cycle timeout.
            if (wr_status) begin
                r_to <= 1'b0;
            end else if (w_event) begin
                r_to <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_word[TO_BIT]  = r_to;
                rd_word[RUN_BIT] = r_run;
            end
            REG_CONTROL: begin
                rd_word[ITO_BIT]  = r_ito;
                rd_word[CONT_BIT] = r_cont;
`ifdef NIOS_TIMER_PRESCALE_EN
                rd_word[PRESC_MSB:PRESC_LSB] = r_presc;
`endif
            end
            REG_PERIOD: rd_word = DATA_W'(r_period);
            REG_SNAP:   rd_word = DATA_W'(r_snap);
        endcase
    end

    assign irq = r_to & r_ito;

endmodule
`default_nettype wire

// File: rtl/nios_multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : nios_multi_timer
// Description : NUM_CH independent interval timers behind one Avalon-MM
//               slave. Holds address decode, the read mux with its
//               registered readdata, and the irq OR-reduction.
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      slave modport: address, chipselect, write_n, writedata,
//            readdata, irq, irq_vec
// Optional feature macro: NIOS_TIMER_PRESCALE_EN (per-channel prescaler)
// Revision    : 1.0  initial release
// ============================================================================
module nios_multi_timer
    import nios_timer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int DATA_W       = 32,
    parameter int RESET_PERIOD = 49999
) (
    input wire logic          clk,
    input wire logic          reset_n,
    nios_multi_timer_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_CH) + 2;

    logic [3:0]        w_ch;
    logic [1:0]        w_reg;
    logic              w_wr;
    logic [DATA_W-1:0] w_rd_word [NUM_CH];
    logic [DATA_W-1:0] w_rd_mux;
    logic [NUM_CH-1:0] w_irq_vec;
    logic [DATA_W-1:0] r_readdata;

    assign w_reg = bus.address[1:0];
    assign w_wr  = bus.chipselect & ~bus.write_n;

    // With a single channel the address carries no channel field.
    generate
        if (NUM_CH > 1) begin : g_ch_field
            assign w_ch = 4'(bus.address[ADDR_W-1:2]);
        end else begin : g_ch_single
            assign w_ch = 4'd0;
        end
    endgenerate

    // Channel numbers >= NUM_CH match no instance: writes vanish, reads give 0.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            logic w_sel;
            assign w_sel = w_wr & (w_ch == 4'(gi));

            nios_timer_channel #(
                .CNT_W        (CNT_W),
                .DATA_W       (DATA_W),
                .RESET_PERIOD (RESET_PERIOD)
            ) u_chan (
                .clk        (clk),
                .reset_n    (reset_n),
                .wr_status  (w_sel & (w_reg == REG_STATUS)),
                .wr_control (w_sel & (w_reg == REG_CONTROL)),
                .wr_period  (w_sel & (w_reg == REG_PERIOD)),
                .wr_snap    (w_sel & (w_reg == REG_SNAP)),
                .wdata      (bus.writedata),
                .reg_sel    (w_reg),
                .rd_word    (w_rd_word[gi]),
                .irq        (w_irq_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == 4'(i)) begin
                w_rd_mux = w_rd_word[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq_vec  = w_irq_vec;
    assign bus.irq      = |w_irq_vec;

endmodule
`default_nettype wire
